pulse_pacer_f: RTL and testbench



---
 rtl/pulse_pacer_f.sv | 108 ++++++++++
 tb/tb_pulse_pacer_f.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_pacer_f.sv
// pulse_pacer_f: fast-domain event pacer feeding cdc_fast2slow.
// Queues ev_in strobes in a saturating pending counter and re-issues them as
// single-cycle pulse_f pulses separated by exactly GAP_CYCLES low cycles.
// Optional feature macro: PULSE_PACER_OVF_EN (sticky ovf flag with ovf_clr).
// Without it ovf is tied low and saturation drops are silent.
module pulse_pacer_f #(
   parameter int GAP_CYCLES = 8,
   parameter int CNT_W      = 4
) (
   input  logic             clk_f,
   input  logic             rst_n,
   input  logic             ev_in,
   input  logic             ovf_clr,
   output logic             pulse_f,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
   output logic             ovf
);

   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP_CYCLES);

   typedef enum logic {IDLE, GAP} state_t;

   state_t           state, state_nxt;
   logic [GW-1:0]    gap_cnt, gap_nxt;
   logic [CNT_W-1:0] pend_nxt;
   logic             issue;
   logic             drop;
   logic             busy_nxt;

   // Next-state logic: issue from IDLE whenever work exists, then count out the gap
   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if ((pending != '0) || ev_in) begin
               issue     = 1'b1;
               gap_nxt   = GAP_LOAD;
               state_nxt = GAP;
            end
         end
         GAP: begin
            gap_nxt = gap_cnt - GW'(1);
            if (gap_cnt == GW'(1)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pending counter update: +ev_in -issue, saturating; simultaneous ev/issue nets to zero
   always_comb begin
      pend_nxt = pending;
      drop     = 1'b0;
      if (ev_in && !issue) begin
         if (pending == PEND_MAX) begin
            drop = 1'b1;
         end else begin
            pend_nxt = pending + CNT_W'(1);
         end
      end else if (!ev_in && issue) begin
         pend_nxt = pending - CNT_W'(1);
      end
      // Busy also covers the final gap cycle spent back in IDLE, so it spans the
      // whole pulse-plus-gap window of GAP_CYCLES+1 cycles.
      busy_nxt = (state_nxt != IDLE) || (pend_nxt != '0) || (state != IDLE);
   end

   // State, gap counter, pending depth and registered outputs
   always_ff @(posedge clk_f or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gap_cnt <= '0;
         pending <= '0;
         pulse_f <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_nxt;
         pending <= pend_nxt;
         pulse_f <= issue;
         busy    <= busy_nxt;
      end
   end

`ifdef PULSE_PACER_OVF_EN
   // Sticky overflow flag; a drop on the same edge as ovf_clr keeps it set
   always_ff @(posedge clk_f or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end
`else
   logic unused_ovf_sig;
   assign unused_ovf_sig = drop | ovf_clr;
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_pacer_f.sv
// Self-checking bench for pulse_pacer_f (GAP_CYCLES=8, CNT_W=4).
// An abstract cooldown/queue model pushes expected outputs per edge into a
// scoreboard; they are popped and compared on the following falling edge.
module tb_pulse_pacer_f;

   localparam int GAP  = 8;
   localparam int CW   = 4;
   localparam int PMAX = 15;

   logic          clk_f = 1'b0;
   logic          rst_n;
   logic          ev_in;
   logic          ovf_clr;
   logic          pulse_f;
   logic          busy;
   logic [CW-1:0] pending;
   logic          ovf;

   pulse_pacer_f #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
      .clk_f   (clk_f),
      .rst_n   (rst_n),
      .ev_in   (ev_in),
      .ovf_clr (ovf_clr),
      .pulse_f (pulse_f),
      .busy    (busy),
      .pending (pending),
      .ovf     (ovf)
   );

   always #5 clk_f = ~clk_f;

   typedef struct packed {
      logic          p;
      logic          b;
      logic          o;
      logic [CW-1:0] pend;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   // reference model state
   int   m_pend;
   int   m_cool;
   bit   m_ovf;

   // per-scenario observations
   int   ecount;
   int   npulse;
   int   nbusy;
   int   maxp;
   int   rise[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0;
      m_cool = 0;
      m_ovf  = 1'b0;
      sbq.delete();
   endtask

   task automatic scen_start();
      ecount = 0;
      npulse = 0;
      nbusy  = 0;
      maxp   = 0;
      rise.delete();
   endtask

   task automatic step(input bit ev, input bit clr);
      exp_t e;
      exp_t g;
      bit   iss;
      bit   drp;
      int   cool_before;
      ev_in   = ev;
      ovf_clr = clr;
      @(posedge clk_f);
      cool_before = m_cool;
      iss = (m_cool == 0) && ((m_pend != 0) || ev);
      drp = ev && !iss && (m_pend == PMAX);
      if (ev && !iss) begin
         if (m_pend < PMAX) m_pend++;
      end else if (!ev && iss) begin
         m_pend--;
      end
      if (iss) m_cool = GAP;
      else if (m_cool > 0) m_cool--;
`ifdef PULSE_PACER_OVF_EN
      if (drp) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
`else
      m_ovf = 1'b0;
`endif
      e.p    = iss;
      e.b    = iss || (cool_before > 0) || (m_pend != 0);
      e.o    = m_ovf;
      e.pend = CW'(m_pend);
      sbq.push_back(e);
      @(negedge clk_f);
      if (sbq.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         g = sbq.pop_front();
         check("pulse_f", pulse_f, g.p);
         check("busy",    busy,    g.b);
         check("pending", pending, g.pend);
         check("ovf",     ovf,     g.o);
      end
      if (pulse_f === 1'b1) begin
         npulse++;
         rise.push_back(ecount + 1);
      end
      if (busy === 1'b1) nbusy++;
      if (int'(pending) > maxp) maxp = int'(pending);
      ecount++;
   endtask

   task automatic do_reset();
      ev_in   = 1'b0;
      ovf_clr = 1'b0;
      rst_n   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_f);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      ev_in   = 1'b0;
      ovf_clr = 1'b0;
      model_reset();
      #3;
      check("rst_pulse_f", pulse_f, 0);
      check("rst_busy",    busy,    0);
      check("rst_pending", pending, 0);
      check("rst_ovf",     ovf,     0);
      @(negedge clk_f);
      @(negedge clk_f);
      rst_n = 1'b1;

      // single event
      scen_start();
      step(1'b1, 1'b0);
      repeat (14) step(1'b0, 1'b0);
      check("single_npulse", npulse, 1);
      check("single_rise",   (rise.size() > 0) ? rise[0] : -1, 1);
      check("single_busy_cycles", nbusy, 9);
      check("single_max_pending", maxp, 0);

      // burst of 5
      do_reset();
      scen_start();
      repeat (5) step(1'b1, 1'b0);
      repeat (45) step(1'b0, 1'b0);
      check("burst_npulse", npulse, 5);
      for (int i = 0; i < 5; i++) begin
         check("burst_rise", (rise.size() > i) ? rise[i] : -1, 1 + 9 * i);
      end
      check("burst_max_pending", maxp, 4);
      check("burst_end_pending", pending, 0);

      // saturation: ev on edges 0..19
      do_reset();
      scen_start();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         if (i == 16) check("sat_pending_full", pending, 15);
`ifdef PULSE_PACER_OVF_EN
         if (i == 16) check("sat_ovf_before_drop", ovf, 0);
         if (i == 17) check("sat_ovf_set", ovf, 1);
`endif
      end
      repeat (150) step(1'b0, 1'b0);
      check("sat_npulse", npulse, 18);
      check("sat_end_pending", pending, 0);
`ifdef PULSE_PACER_OVF_EN
      check("sat_ovf_sticky", ovf, 1);
      step(1'b0, 1'b1);
      check("sat_ovf_cleared", ovf, 0);
`else
      check("sat_ovf_tied", ovf, 0);
`endif

      // simultaneous issue at full, then drop together with ovf_clr
      do_reset();
      scen_start();
      repeat (17) step(1'b1, 1'b0);
      check("full_pending", pending, 15);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("full_simul_pulse",   pulse_f, 1);
      check("full_simul_pending", pending, 15);
      check("full_simul_ovf",     ovf,     0);
      step(1'b1, 1'b1);
`ifdef PULSE_PACER_OVF_EN
      check("clr_vs_drop_ovf", ovf, 1);
      step(1'b0, 1'b1);
      check("clr_ovf", ovf, 0);
`else
      check("clr_vs_drop_ovf_tied", ovf, 0);
`endif

      // reset during the pulse cycle of GAP with pending=6
      do_reset();
      scen_start();
      repeat (8) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      check("pre_rst_pulse",   pulse_f, 1);
      check("pre_rst_pending", pending, 6);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_pulse_f", pulse_f, 0);
      check("midrst_pending", pending, 0);
      check("midrst_busy",    busy,    0);
      check("midrst_ovf",     ovf,     0);
      @(negedge clk_f);
      rst_n = 1'b1;
      scen_start();
      repeat (20) step(1'b0, 1'b0);
      check("post_rst_npulse", npulse, 0);
      step(1'b1, 1'b0);
      check("post_rst_new_pulse", pulse_f, 1);
      repeat (10) step(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
